// File: rtl/regfile_pkg.sv
// Shared types and defaults for the two-read, one-write register file.
package regfile_pkg;

    localparam int REGFILE_WIDTH_DEF = 16;
    localparam int REGFILE_DEPTH_DEF = 8;

    typedef struct packed {
        logic [REGFILE_WIDTH_DEF-1:0] data;
        logic                         valid;
    } rd_resp_t;

    function automatic logic in_range(
        input int unsigned addr,
        input int unsigned depth
    );
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: entry mux, write bypass, clear and valid masking.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int  WIDTH  = REGFILE_WIDTH_DEF,
    parameter int  DEPTH  = REGFILE_DEPTH_DEF,
    parameter int  ADDR_W = $clog2(DEPTH),
    parameter type resp_t = rd_resp_t
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic [DEPTH-1:0]            vld,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        clear,
    output resp_t                       resp
);

    resp_t resp_d;
    logic  hit;

    always_comb begin
        resp_d = '0;
        hit    = in_range(32'(addr), DEPTH);
        // wr_en is already qualified by an in-range write address
        if (wr_en && (wr_addr == addr)) begin
            resp_d.data  = wr_data;
            resp_d.valid = 1'b1;
        end else if (clear) begin
            resp_d = '0;
        end else if (hit && vld[addr]) begin
            resp_d.data  = mem[addr];
            resp_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp <= '0;
        end else begin
            resp <= resp_d;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one write port, two registered read ports and flash clear.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter  int WIDTH  = REGFILE_WIDTH_DEF,
    parameter  int DEPTH  = REGFILE_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    input  logic              clear,
    output logic [WIDTH-1:0]  data_out_a,
    output logic [WIDTH-1:0]  data_out_b,
    output logic              valid_a,
    output logic              valid_b
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             valid;
    } resp_t;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            vld;
    logic                        wr_en;
    resp_t                       resp_a;
    resp_t                       resp_b;

    assign wr_en = write && in_range(32'(writenum), DEPTH);

    // The write lands after the clear so it wins for its own entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
            vld <= '0;
        end else begin
            if (clear) begin
                vld <= '0;
            end
            if (wr_en) begin
                mem[writenum] <= data_in;
                vld[writenum] <= 1'b1;
            end
        end
    end

    regfile_rdport #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .resp_t (resp_t)
    ) u_rd_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (readnum_a),
        .mem     (mem),
        .vld     (vld),
        .wr_en   (wr_en),
        .wr_addr (writenum),
        .wr_data (data_in),
        .clear   (clear),
        .resp    (resp_a)
    );

    regfile_rdport #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .resp_t (resp_t)
    ) u_rd_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (readnum_b),
        .mem     (mem),
        .vld     (vld),
        .wr_en   (wr_en),
        .wr_addr (writenum),
        .wr_data (data_in),
        .clear   (clear),
        .resp    (resp_b)
    );

    assign data_out_a = resp_a.data;
    assign valid_a    = resp_a.valid;
    assign data_out_b = resp_b.data;
    assign valid_b    = resp_b.valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench: directed vectors on an 8-entry and a 5-entry instance.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic        clear;

    logic [15:0] dout_a, dout_b, dout5_a, dout5_b;
    logic        val_a, val_b, val5_a, val5_b;

    int n_chk  = 0;
    int n_fail = 0;
    int tag    = 0;

    typedef struct {
        int          tag;
        logic [15:0] ad;
        logic        av;
        logic [15:0] bd;
        logic        bv;
        logic        c5;
        logic [15:0] ad5;
        logic        av5;
        logic [15:0] bd5;
        logic        bv5;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    regfile_2r1w dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .writenum   (writenum),
        .write      (write),
        .readnum_a  (readnum_a),
        .readnum_b  (readnum_b),
        .clear      (clear),
        .data_out_a (dout_a),
        .data_out_b (dout_b),
        .valid_a    (val_a),
        .valid_b    (val_b)
    );

    regfile_2r1w #(.WIDTH(16), .DEPTH(5)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .writenum   (writenum),
        .write      (write),
        .readnum_a  (readnum_a),
        .readnum_b  (readnum_b),
        .clear      (clear),
        .data_out_a (dout5_a),
        .data_out_b (dout5_b),
        .valid_a    (val5_a),
        .valid_b    (val5_b)
    );

    task automatic chk(input int t, input string nm,
                       input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h expected %h", t, nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "data_a", dout_a, e.ad);
            chk(e.tag, "valid_a", {15'd0, val_a}, {15'd0, e.av});
            chk(e.tag, "data_b", dout_b, e.bd);
            chk(e.tag, "valid_b", {15'd0, val_b}, {15'd0, e.bv});
            if (e.c5) begin
                chk(e.tag, "d5_data_a", dout5_a, e.ad5);
                chk(e.tag, "d5_valid_a", {15'd0, val5_a}, {15'd0, e.av5});
                chk(e.tag, "d5_data_b", dout5_b, e.bd5);
                chk(e.tag, "d5_valid_b", {15'd0, val5_b}, {15'd0, e.bv5});
            end
        end
    end

    task automatic step(
        input logic w, input logic [2:0] wn, input logic [15:0] d,
        input logic clr, input logic [2:0] ra, input logic [2:0] rb,
        input logic [15:0] ead, input logic eav,
        input logic [15:0] ebd, input logic ebv,
        input logic c5 = 1'b0,
        input logic [15:0] ead5 = '0, input logic eav5 = 1'b0,
        input logic [15:0] ebd5 = '0, input logic ebv5 = 1'b0
    );
        exp_t e;
        @(negedge clk);
        write     = w;
        writenum  = wn;
        data_in   = d;
        clear     = clr;
        readnum_a = ra;
        readnum_b = rb;
        @(posedge clk);
        #1;
        tag++;
        e = '{tag, ead, eav, ebd, ebv, c5, ead5, eav5, ebd5, ebv5};
        sb.push_back(e);
    endtask

    task automatic chk_zero(input int t);
        chk(t, "rst_data_a", dout_a, 16'h0);
        chk(t, "rst_valid_a", {15'd0, val_a}, 16'h0);
        chk(t, "rst_data_b", dout_b, 16'h0);
        chk(t, "rst_valid_b", {15'd0, val_b}, 16'h0);
        chk(t, "rst5_data_a", dout5_a, 16'h0);
        chk(t, "rst5_data_b", dout5_b, 16'h0);
    endtask

    initial begin
        rst_n     = 1'b1;
        data_in   = '0;
        writenum  = '0;
        write     = 1'b0;
        readnum_a = '0;
        readnum_b = '0;
        clear     = 1'b0;
        #1 rst_n  = 1'b0;
        #1 chk_zero(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // all entries unwritten after reset
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0, 0, 3'(i), 3'(i + 4),
                 16'h0, 0, 16'h0, 0, 1, 16'h0, 0, 16'h0, 0);
        end

        // write r0, read back next cycle
        step(1, 0, 16'h00AA, 0, 1, 2, 16'h0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0, 0, 3, 16'h00AA, 1, 16'h0, 0);

        // bypass on both ports
        step(1, 3, 16'h5555, 0, 3, 3, 16'h5555, 1, 16'h5555, 1);

        // clear wipes valid entries
        step(1, 7, 16'h00F0, 0, 0, 3, 16'h00AA, 1, 16'h5555, 1);
        step(1, 2, 16'h1234, 0, 7, 2, 16'h00F0, 1, 16'h1234, 1);
        step(0, 0, 16'h0, 1, 7, 2, 16'h0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0, 7, 0, 16'h0, 0, 16'h0, 0);
        step(1, 7, 16'h00F0, 0, 3, 4, 16'h0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0, 7, 2, 16'h00F0, 1, 16'h0, 0);

        // clear with simultaneous write
        step(1, 5, 16'hBEEF, 1, 5, 7, 16'hBEEF, 1, 16'h0, 0);
        step(0, 0, 16'h0, 0, 5, 7, 16'hBEEF, 1, 16'h0, 0);

        // out-of-range on the 5-entry instance
        step(1, 4, 16'h4444, 0, 4, 5, 16'h4444, 1, 16'hBEEF, 1,
             1, 16'h4444, 1, 16'h0, 0);
        step(1, 6, 16'hDEAD, 0, 6, 4, 16'hDEAD, 1, 16'h4444, 1,
             1, 16'h0, 0, 16'h4444, 1);
        step(0, 0, 16'h0, 0, 6, 4, 16'hDEAD, 1, 16'h4444, 1,
             1, 16'h0, 0, 16'h4444, 1);

        // asynchronous reset in the middle of a write
        @(negedge clk);
        write     = 1'b1;
        writenum  = 3'd1;
        data_in   = 16'h7777;
        readnum_a = 3'd4;
        readnum_b = 3'd6;
        #2 rst_n  = 1'b0;
        #1 chk_zero(100);
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 16'h0, 0, 1, 4, 16'h0, 0, 16'h0, 0,
             1, 16'h0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0, 6, 5, 16'h0, 0, 16'h0, 0,
             1, 16'h0, 0, 16'h0, 0);

        for (int i = 0; i < 8 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk(999, "sb_drain", 16'(sb.size()), 16'h0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised successor to the 8×16 single-port register file: one write port, two independent read ports, registered read outputs, write-to-read bypass, per-entry valid bits and a single-cycle flash clear. It sits in the datapath and feeds the A and B operand paths in the same cycle. Contents are fully defined after reset, so reading an unwritten register returns zero rather than X.

## Interface
Parameters:
- WIDTH, 16, data width of each entry in bits
- DEPTH, 8, number of entries (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), localparam, address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  WIDTH  write data
- writenum  in  ADDR_W  write address
- write  in  1  write enable
- readnum_a  in  ADDR_W  read address, port A
- readnum_b  in  ADDR_W  read address, port B
- clear  in  1  flash-invalidate all entries
- data_out_a  out  WIDTH  registered read data, port A
- data_out_b  out  WIDTH  registered read data, port B
- valid_a  out  1  entry read on port A holds written data
- valid_b  out  1  entry read on port B holds written data

## Operation
- Storage: DEPTH × WIDTH entries plus a DEPTH-bit valid vector.
- Reset (rst_n low, asynchronous): all entries 0, all valid bits 0, data_out_a/b 0, valid_a/b 0. Outputs hold these values until the first rising edge after rst_n goes high.
- Write: on a rising edge with write=1 and writenum < DEPTH, entry[writenum] ← data_in and valid[writenum] ← 1.
- Clear: on a rising edge with clear=1, every valid bit ← 0. Entry data is left unchanged, but invalid entries always read as 0.
- Clear and write in the same cycle: the write takes priority for its entry, which ends valid=1 holding data_in. All other entries end invalid.
- Read (per port p ∈ {a,b}): on each rising edge, data_out_p / valid_p are loaded from the entry at readnum_p:
  - Bypass: if write=1 and writenum==readnum_p in that cycle, load data_in and valid 1, regardless of clear.
  - Otherwise, if clear=1, load 0 and valid 0.
  - Otherwise, if the entry is valid, load its data and valid 1.
  - Otherwise, load 0 and valid 0.
- Out-of-range address (≥DEPTH): the write is ignored with no side effect; a read returns 0 and valid 0.
- The two read ports are fully independent. Both may address the same entry, including the entry being written.
- No read enable: outputs update every cycle.

## Timing
- Read latency is 1 cycle. Address presented before edge N gives data after edge N, stable until edge N+1.
- Write latency is 0 cycles through the bypass. A read sampled at the same edge as a write to that address returns the new data.
- Clear takes effect at the edge where it is sampled. A read sampled at that edge already sees invalid entries, except the bypassed write.
- Reset may assert at any time, including mid-write; it overrides everything immediately. No write may take effect while rst_n is low.
- No combinational path from any input to any output.

## Structure
- Package regfile_pkg:
  - REGFILE_WIDTH_DEF = 16 and REGFILE_DEPTH_DEF = 8.
  - typedef rd_resp_t {data, valid}, used for the read outputs of the sub-module.
- Sub-module regfile_rdport, instantiated twice:
  - Inputs: address, storage and valid vectors, write/bypass signals, clear.
  - Function: entry mux, bypass/clear/valid priority logic and the output register.
  - Output: one rd_resp_t.
- Top level holds storage, the valid vector and the write/clear logic.

## Test plan
- Reset, then read every address on both ports → data_out=0 and valid=0 for all 8 entries. Assert rst_n mid-run → outputs go to 0 with no clock edge.
- Write 16'h00AA to r0, then read r0 on A and r3 on B the next cycle → A = 00AA/valid 1; B = 0000/valid 0.
- In one cycle, write 16'h5555 to r3 with readnum_a=readnum_b=3 → after that edge, both ports show 5555/valid 1 (bypass).
- Write r7=16'h00F0 and r2=16'h1234, then pulse clear → r7 and r2 read as 0/valid 0. Rewrite r7 → reads 00F0/valid 1.
- Assert clear together with a write of 16'hBEEF to r5, readnum_a=5 and readnum_b=7 (r7 previously valid) → A = BEEF/1; B = 0/0. On the following cycle r5 is still valid.
- With DEPTH=5, write to address 6, then read addresses 6 and 4 → no entry changes; address 6 reads 0/valid 0.
